mole_spawner: RTL and testbench

Game sequencer directly upstream of board_state. It picks pseudo-random mole patterns and drives board_state's load/loadval interface. Each round shows a pattern for a show window, then clears the board and waits out a gap. The show window shrinks every round, and the block signals game over after a fixed number of rounds.

---
 rtl/mole_spawner_if.sv | 20 ++
 rtl/mole_spawner.sv | 134 +++++++++++++
 tb/tb_mole_spawner.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mole_spawner_if.sv
// Load/pattern interface between the mole sequencer and the board state block,
// plus the game control and status signals that travel with it.
interface mole_spawner_if;
  logic       start;
  logic [4:0] board_state;
  logic       load;
  logic [4:0] loadval;
  logic [7:0] round;
  logic       game_over;

  modport master (
    input  start, board_state,
    output load, loadval, round, game_over
  );

  modport slave (
    output start, board_state,
    input  load, loadval, round, game_over
  );
endinterface

// File: rtl/mole_spawner.sv
// Game sequencer: shows LFSR-derived mole patterns for a shrinking show window,
// clears the board for a fixed gap, and flags game over after ROUNDS rounds.
module mole_spawner #(
  parameter int unsigned SHOW_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES  = 10000000,
  parameter int unsigned ROUNDS      = 30,
  parameter int unsigned SPEEDUP     = 1000000,
  parameter int unsigned MIN_SHOW    = 10000000,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input logic      clk,
  input logic      rst_n,
  mole_spawner_if.master bus
);

  localparam int unsigned MAX_CYC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int          CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] SHOW_INIT = CW'(SHOW_CYCLES);
  localparam logic [CW-1:0] GAP_LEN   = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] MIN_LEN   = CW'(MIN_SHOW);
  localparam logic [CW-1:0] SPD_LEN   = CW'(SPEEDUP);
  localparam logic [7:0]    LAST_RND  = 8'(ROUNDS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]    state_reg, state_next;
  logic [15:0]   lfsr_reg, lfsr_next;
  logic [CW-1:0] show_len_reg, show_len_next;
  logic [CW-1:0] counter_reg, counter_next;
  logic          load_reg, load_next;
  logic [4:0]    loadval_reg, loadval_next;
  logic [7:0]    round_reg, round_next;
  logic          game_over_reg, game_over_next;

  logic [4:0]    pat;
  logic [CW-1:0] shrunk_len;
  logic          show_exit;

  // Zero is never a useful mole pattern, so substitute the centre hole.
  assign pat = (lfsr_reg[4:0] == 5'd0) ? 5'b00100 : lfsr_reg[4:0];

  // Saturating shrink evaluated in 32 bits so MIN_SHOW + SPEEDUP cannot wrap.
  assign shrunk_len = (32'(show_len_reg) >= (MIN_SHOW + SPEEDUP)) ?
                      (show_len_reg - SPD_LEN) : MIN_LEN;

  // board_state trails load by a register, so cycles 0-1 still show the old board.
  assign show_exit = (counter_reg == show_len_reg) ||
                     ((bus.board_state == 5'd0) && (counter_reg >= CW'(2)));

  always_comb begin
    state_next     = state_reg;
    lfsr_next      = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    show_len_next  = show_len_reg;
    counter_next   = counter_reg;
    load_next      = 1'b0;
    loadval_next   = loadval_reg;
    round_next     = round_reg;
    game_over_next = game_over_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_next     = ST_SHOW;
          load_next      = 1'b1;
          loadval_next   = pat;
          round_next     = 8'd1;
          counter_next   = '0;
          game_over_next = 1'b0;
          show_len_next  = SHOW_INIT;
        end
      end
      ST_SHOW: begin
        if (show_exit) begin
          state_next    = ST_GAP;
          load_next     = 1'b1;
          loadval_next  = 5'd0;
          counter_next  = '0;
          show_len_next = shrunk_len;
        end else begin
          counter_next = counter_reg + CW'(1);
        end
      end
      ST_GAP: begin
        if (counter_reg == GAP_LEN) begin
          counter_next = '0;
          if (round_reg == LAST_RND) begin
            state_next     = ST_DONE;
            game_over_next = 1'b1;
          end else begin
            state_next   = ST_SHOW;
            round_next   = round_reg + 8'd1;
            load_next    = 1'b1;
            loadval_next = pat;
          end
        end else begin
          counter_next = counter_reg + CW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      lfsr_reg      <= SEED;
      show_len_reg  <= SHOW_INIT;
      counter_reg   <= '0;
      load_reg      <= 1'b0;
      loadval_reg   <= 5'd0;
      round_reg     <= 8'd0;
      game_over_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lfsr_reg      <= lfsr_next;
      show_len_reg  <= show_len_next;
      counter_reg   <= counter_next;
      load_reg      <= load_next;
      loadval_reg   <= loadval_next;
      round_reg     <= round_next;
      game_over_reg <= game_over_next;
    end
  end

  assign bus.load      = load_reg;
  assign bus.loadval   = loadval_reg;
  assign bus.round     = round_reg;
  assign bus.game_over = game_over_reg;

endmodule

// File: tb/tb_mole_spawner.sv
// Bench for mole_spawner: two instances (show 20 and show 12) with short timings,
// checked against event timing derived from the game rules and an LFSR pattern model.
module tb_mole_spawner;
  localparam int          SHOW  = 20;
  localparam int          SHOW2 = 12;
  localparam int          GAP   = 5;
  localparam int          RND   = 3;
  localparam int          SPD   = 4;
  localparam int          MINS  = 10;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mole_spawner_if bus1();
  mole_spawner_if bus2();

  mole_spawner #(.SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .ROUNDS(RND), .SPEEDUP(SPD),
                 .MIN_SHOW(MINS), .SEED(SEED))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  mole_spawner #(.SHOW_CYCLES(SHOW2), .GAP_CYCLES(GAP), .ROUNDS(RND), .SPEEDUP(SPD),
                 .MIN_SHOW(MINS), .SEED(SEED))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [4:0] pat_of(input logic [15:0] s);
    return (s[4:0] == 5'd0) ? 5'b00100 : s[4:0];
  endfunction

  function automatic int next_len(input int l);
    return (l - SPD < MINS) ? MINS : l - SPD;
  endfunction

  // Reference LFSR; model_prev holds the value the DUT saw at the most recent edge.
  logic [15:0] model_lfsr, model_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_lfsr <= SEED;
      model_prev <= SEED;
    end else begin
      model_prev <= model_lfsr;
      model_lfsr <= lfsr_step(model_lfsr);
    end
  end

  function automatic logic get_load(input int which);
    return (which == 1) ? bus1.load : bus2.load;
  endfunction

  function automatic logic [4:0] get_val(input int which);
    return (which == 1) ? bus1.loadval : bus2.loadval;
  endfunction

  function automatic logic [7:0] get_round(input int which);
    return (which == 1) ? bus1.round : bus2.round;
  endfunction

  function automatic logic get_go(input int which);
    return (which == 1) ? bus1.game_over : bus2.game_over;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    bus1.start = 1'b0; bus2.start = 1'b0;
    bus1.board_state = 5'h1f; bus2.board_state = 5'h1f;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 1) bus1.start = v; else bus2.start = v;
  endtask

  task automatic wait_load(input int which, input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (get_load(which)) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    int nload;
    apply_reset();
    tests++;
    if ({bus1.load, bus1.loadval, bus1.round, bus1.game_over} !== 15'd0) begin
      fails++;
      $display("FAIL reset_state: load=%b loadval=%h round=%0d game_over=%b, required all 0",
               bus1.load, bus1.loadval, bus1.round, bus1.game_over);
    end
    bus1.start = 1'b1; tick(); bus1.start = 1'b0;
    tests++;
    if (bus1.load !== 1'b1) begin
      fails++; $display("FAIL reset_pre_load: load=%b required 1", bus1.load);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus1.load, bus1.loadval, bus1.round, bus1.game_over} !== 15'd0) begin
      fails++;
      $display("FAIL reset_async: load=%b loadval=%h round=%0d game_over=%b, required all 0",
               bus1.load, bus1.loadval, bus1.round, bus1.game_over);
    end
    tick(); tick();
    rst_n = 1'b1;
    nload = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus1.load || bus1.round != 8'd0) nload++;
    end
    tests++;
    if (nload != 0) begin
      fails++; $display("FAIL reset_idle: %0d active cycles after release, required 0", nload);
    end
  endtask

  task automatic test_start_timing();
    int t;
    bit found;
    apply_reset();
    repeat ($urandom_range(0, 15)) tick();
    t = cyc;
    bus1.start = 1'b1; tick(); bus1.start = 1'b0;
    tests++;
    if (bus1.load !== 1'b1 || bus1.round !== 8'd1 || bus1.loadval !== pat_of(model_prev)
        || bus1.loadval == 5'd0) begin
      fails++;
      $display("FAIL start_first_load: load=%b round=%0d loadval=%h, required 1/1/%h",
               bus1.load, bus1.round, bus1.loadval, pat_of(model_prev));
    end
    wait_load(1, 40, found);
    tests++;
    if (!found || cyc != t + 22 || bus1.loadval !== 5'd0) begin
      fails++;
      $display("FAIL start_clear: found=%b at T+%0d loadval=%h, required T+22 loadval 0",
               found, cyc - t, bus1.loadval);
    end
    wait_load(1, 40, found);
    tests++;
    if (!found || cyc != t + 28 || bus1.round !== 8'd2 || bus1.loadval !== pat_of(model_prev)) begin
      fails++;
      $display("FAIL start_round2: found=%b at T+%0d round=%0d loadval=%h, required T+28 round 2 loadval %h",
               found, cyc - t, bus1.round, bus1.loadval, pat_of(model_prev));
    end
  endtask

  task automatic run_game(input int which, input int show_init);
    int  sl, t_mole, t_clear;
    bit  found;
    apply_reset();
    sl = show_init;
    t_clear = 0;
    set_start(which, 1'b1); tick(); set_start(which, 1'b0);
    for (int r = 1; r <= RND; r++) begin
      if (r == 1) begin
        found = get_load(which);
      end else begin
        wait_load(which, 40, found);
      end
      tests++;
      if (!found || get_round(which) != 8'(r) || get_val(which) == 5'd0
          || (r > 1 && cyc != t_clear + GAP + 1)) begin
        fails++;
        $display("FAIL game%0d_mole_r%0d: found=%b round=%0d loadval=%h gap=%0d, required round %0d gap %0d",
                 which, r, found, get_round(which), get_val(which), cyc - t_clear, r, GAP + 1);
      end
      t_mole = cyc;
      wait_load(which, 60, found);
      tests++;
      if (!found || get_val(which) !== 5'd0 || cyc - t_mole != sl + 1) begin
        fails++;
        $display("FAIL game%0d_window_r%0d: found=%b window=%0d loadval=%h, required window %0d loadval 0",
                 which, r, found, cyc - t_mole - 1, get_val(which), sl);
      end
      t_clear = cyc;
      sl = next_len(sl);
    end
    repeat (GAP) tick();
    tests++;
    if (get_go(which) !== 1'b0) begin
      fails++; $display("FAIL game%0d_go_early: game_over=%b at clear+%0d, required 0", which, get_go(which), GAP);
    end
    tick();
    tests++;
    if (get_go(which) !== 1'b1 || get_round(which) != 8'(RND) || get_load(which) !== 1'b0) begin
      fails++;
      $display("FAIL game%0d_go: game_over=%b round=%0d load=%b, required 1/%0d/0",
               which, get_go(which), get_round(which), get_load(which), RND);
    end
  endtask

  task automatic test_speedup();
    run_game(1, SHOW);
  endtask

  task automatic test_floor();
    run_game(2, SHOW2);
  endtask

  task automatic test_early_clear();
    int  k, t0, t_clear;
    bit  found;
    apply_reset();
    bus1.start = 1'b1; tick(); bus1.start = 1'b0;
    k = $urandom_range(2, 10);
    for (int c = 1; c <= k; c++) tick();
    bus1.board_state = 5'd0;
    tick();
    bus1.board_state = 5'h1f;
    tests++;
    if (bus1.load !== 1'b1 || bus1.loadval !== 5'd0) begin
      fails++;
      $display("FAIL early_clear: load=%b loadval=%h after zero board at cycle %0d, required 1/0",
               bus1.load, bus1.loadval, k);
    end
    t_clear = cyc;
    wait_load(1, 40, found);
    tests++;
    if (!found || cyc != t_clear + GAP + 1 || bus1.round !== 8'd2) begin
      fails++;
      $display("FAIL early_gap: found=%b gap=%0d round=%0d, required gap %0d round 2",
               found, cyc - t_clear, bus1.round, GAP + 1);
    end
    t0 = cyc;
    tick();
    bus1.board_state = 5'd0;
    tick();
    bus1.board_state = 5'h1f;
    wait_load(1, 60, found);
    tests++;
    if (!found || cyc - t0 != next_len(SHOW) + 1) begin
      fails++;
      $display("FAIL early_ignore_c1: found=%b window=%0d, required %0d",
               found, cyc - t0 - 1, next_len(SHOW));
    end
  endtask

  task automatic test_restart_guard();
    int  t0, nload, t_first, t_second;
    bit  done;
    apply_reset();
    bus1.start = 1'b1; tick(); bus1.start = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (bus1.game_over) done = 1'b1;
    end
    tests++;
    if (!done) begin
      fails++; $display("FAIL restart_reach_done: game_over=%b after 200 cycles, required 1", bus1.game_over);
    end
    bus1.start = 1'b1;
    tick();
    tests++;
    if (bus1.load !== 1'b1 || bus1.game_over !== 1'b0 || bus1.round !== 8'd1 || bus1.loadval == 5'd0) begin
      fails++;
      $display("FAIL restart_load: load=%b game_over=%b round=%0d loadval=%h, required 1/0/1/nonzero",
               bus1.load, bus1.game_over, bus1.round, bus1.loadval);
    end
    t0 = cyc;
    nload = 0; t_first = -1; t_second = -1;
    for (int i = 1; i <= SHOW + GAP + 2; i++) begin
      tick();
      if (bus1.load) begin
        nload++;
        if (t_first < 0) t_first = cyc - t0; else t_second = cyc - t0;
      end
    end
    bus1.start = 1'b0;
    tests++;
    if (nload != 2 || t_first != SHOW + 1 || t_second != SHOW + GAP + 2 || bus1.round !== 8'd2) begin
      fails++;
      $display("FAIL restart_guard: loads=%0d at +%0d,+%0d round=%0d, required 2 at +%0d,+%0d round 2",
               nload, t_first, t_second, bus1.round, SHOW + 1, SHOW + GAP + 2);
    end
  endtask

  task automatic test_patterns();
    int   moles, idle, nfail_local;
    logic prev_load, expect_mole;
    logic [7:0] exp_round;
    apply_reset();
    bus1.start = 1'b1;
    moles = 0; idle = 0; prev_load = 1'b0; expect_mole = 1'b1;
    for (int i = 0; i < 60000 && moles < 1000; i++) begin
      tick();
      bus1.board_state = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if (bus1.load) begin
        idle = 0;
        tests++;
        if (prev_load) begin
          fails++; $display("FAIL pattern_consecutive: load high on two cycles at cycle %0d", cyc);
        end
        tests++;
        if (expect_mole) begin
          exp_round = 8'((moles % RND) + 1);
          if (bus1.loadval == 5'd0 || bus1.loadval !== pat_of(model_prev) || bus1.round !== exp_round) begin
            fails++;
            $display("FAIL pattern_mole%0d: loadval=%h round=%0d, required %h round %0d",
                     moles, bus1.loadval, bus1.round, pat_of(model_prev), exp_round);
          end
          moles++;
        end else if (bus1.loadval !== 5'd0) begin
          fails++; $display("FAIL pattern_clear: loadval=%h required 0", bus1.loadval);
        end
        expect_mole = ~expect_mole;
      end else begin
        idle++;
        if (idle > SHOW + GAP + 10) begin
          tests++; fails++;
          $display("FAIL pattern_stall: no load for %0d cycles, required <= %0d", idle, SHOW + GAP + 10);
          break;
        end
      end
      prev_load = bus1.load;
    end
    nfail_local = (moles < 1000) ? 1 : 0;
    tests++;
    if (nfail_local != 0) begin
      fails++; $display("FAIL pattern_count: %0d mole loads seen, required 1000", moles);
    end
    bus1.start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_timing();
    test_speedup();
    test_floor();
    test_early_clear();
    test_restart_guard();
    test_patterns();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
